sm2201_camac_cycle_controller: RTL
==================================

# sm2201_camac_cycle_controller

Sequencer that turns ISA I/O commands in the SM2201 address window into CAMAC dataway cycles (N, A, F, S1, S2). It sits between the ISA decode front end and the CAMAC dataway drivers on the sm2201 interface board. It holds `isa_chrdy` low for the full CAMAC cycle and latches the Q/X responses into a status register readable from ISA.

## Interface
Parameters:
- `BASE_ADDR`, 10'h300: base of the 32-byte I/O window; must be 32-aligned.
- `T_SETUP`, 1: isa_clk cycles of N/A/F setup before S1 (≥1).
- `T_S1`, 2: S1 width in isa_clk cycles (≥1).
- `T_S2`, 2: S2 width in isa_clk cycles (≥1).
- `B_TIMEOUT`, 64: max cycles waiting for dataway busy `camac_b` to clear.

Ports:
- `isa_clk` in 1: sole clock, all logic on rising edge.
- `isa_reset` in 1: asynchronous, active-low reset.
- `isa_addr` in 10: ISA I/O address.
- `isa_ior` in 1: I/O read command, active-low.
- `isa_iow` in 1: I/O write command, active-low.
- `isa_aen` in 1: high = DMA cycle; block ignores the bus.
- `isa_data_in` in 8: ISA write data.
- `isa_chrdy` out 1: low = insert wait states.
- `camac_b` in 1: dataway busy from crate, active-high.
- `camac_q`, `camac_x` in 1 each: crate responses, active-high.
- `camac_n` out 5, `camac_a` out 4, `camac_f` out 5: station, subaddress, function.
- `camac_s1`, `camac_s2` out 1 each: strobes, active-high.
- `camac_busy` out 1: high while the controller owns the dataway.
- `rd_latch_en` out 1: one-cycle pulse; external read-data latch captures the dataway.
- `status` out 8: {5'b0, timeout, x, q}.

## Operation
- Window hit: `isa_addr[9:5] == BASE_ADDR[9:5]` and `isa_aen == 0`.
- Command start: registered `isa_ior`/`isa_iow` sampled high on the previous cycle and low now, exactly one of them low. Both low or `isa_aen` high: no action.
- Offset 0x00, write: `n_reg <= isa_data_in[4:0]`. Offset 0x01, write: `f_reg <= isa_data_in[4:0]`. Offset 0x02, read: status (mux external). All other offsets below 0x10: no action, no wait states.
- Offsets 0x10–0x1F, read or write: CAMAC cycle with A = `isa_addr[3:0]` and N/F from the registers. Reads and writes use the same sequence.
- FSM states:
  - IDLE: on cycle start, go to WAIT_B, drive `isa_chrdy` low, clear `status`, latch A.
  - WAIT_B: go to SETUP when `camac_b == 0`. After `B_TIMEOUT` cycles, set timeout and go to DONE with no strobes.
  - SETUP (`T_SETUP`) -> S1 (`T_S1`) -> GAP (1) -> S2 (`T_S2`) -> DONE.
  - DONE: `isa_chrdy` high. Return to IDLE when both `isa_ior` and `isa_iow` are high.
- `camac_busy` is high in SETUP through S2.
- `camac_n/a/f` are driven from the latched values in SETUP through S2 and are 0 otherwise.
- On the last S1 cycle, `camac_q`/`camac_x` are latched into `status[0]`/`[1]`.
- `rd_latch_en` pulses on the last S1 cycle only when `f_reg[4:3] == 2'b00` (F0–F7 read functions).
- Status bits stay sticky until the next CAMAC cycle starts.
- Command released before DONE: the sequence still completes, so strobe timing is never truncated. The block then goes DONE -> IDLE with no new start.
- Register writes during a CAMAC cycle cannot occur, because chrdy blocks the bus.

## Timing
- Reset values: `isa_chrdy`=1, `camac_n/a/f`=0, `camac_s1`=`camac_s2`=0, `camac_busy`=0, `rd_latch_en`=0, `status`=0, `n_reg`=`f_reg`=0, state IDLE.
- Reset asserted mid-cycle: strobes drop immediately (async) and `isa_chrdy` releases high.
- Start detect: `isa_chrdy` goes low on the first edge after the command is sampled low, one-cycle latency.
- With `camac_b`=0, `isa_chrdy` is low for exactly 1 (WAIT_B) + `T_SETUP` + `T_S1` + 1 + `T_S2` cycles; with defaults that is 7 cycles.
- The timeout counter is 8 bits and saturates. Timeout is flagged on the cycle the count reaches `B_TIMEOUT`.

## Test plan
- Reset: hold `isa_reset`=0 -> every output at its reset value, with `isa_chrdy`=1.
- Register write then cycle: iow to 0x300 with data 0x05, iow to 0x301 with 0x10, then iow to 0x313 -> N=5, A=3, F=16 on the dataway. S1 lasts 2 cycles after 1 setup cycle, S2 lasts 2 cycles after a 1-cycle gap, and `isa_chrdy` is low for 7 cycles.
- Read cycle: set F=0, `camac_q`=1, `camac_x`=1, then ior to 0x310 -> one `rd_latch_en` pulse on the second S1 cycle and `status`=8'h03.
- Busy timeout: hold `camac_b`=1 and ior to 0x310 -> no S1/S2, `status`=8'h04, and `isa_chrdy` returns high after 65 cycles.
- Ignored commands: `isa_aen`=1, ior and iow both low, or an address outside the window -> no state change and `isa_chrdy` stays 1.
- Reset mid-S1 -> `camac_s1`=0 and `isa_chrdy`=1 immediately. A subsequent command runs a clean cycle.

Source files
------------

// File: rtl/sm2201_camac_cycle_controller_if.sv
// ISA-side and CAMAC-dataway signals of the SM2201 cycle controller.
// The master is the ISA front end plus crate; the slave is the controller.
interface sm2201_camac_cycle_controller_if;
  logic [9:0] isa_addr;
  logic       isa_ior;
  logic       isa_iow;
  logic       isa_aen;
  logic [7:0] isa_data_in;
  logic       isa_chrdy;
  logic       camac_b;
  logic       camac_q;
  logic       camac_x;
  logic [4:0] camac_n;
  logic [3:0] camac_a;
  logic [4:0] camac_f;
  logic       camac_s1;
  logic       camac_s2;
  logic       camac_busy;
  logic       rd_latch_en;
  logic [7:0] status;

  modport master (
    output isa_addr, isa_ior, isa_iow, isa_aen, isa_data_in,
    output camac_b, camac_q, camac_x,
    input  isa_chrdy, camac_n, camac_a, camac_f, camac_s1, camac_s2,
    input  camac_busy, rd_latch_en, status
  );

  modport slave (
    input  isa_addr, isa_ior, isa_iow, isa_aen, isa_data_in,
    input  camac_b, camac_q, camac_x,
    output isa_chrdy, camac_n, camac_a, camac_f, camac_s1, camac_s2,
    output camac_busy, rd_latch_en, status
  );
endinterface

// File: rtl/sm2201_camac_cycle_controller.sv
// Turns ISA I/O commands in the SM2201 window into timed CAMAC dataway cycles,
// stretching the ISA cycle with chrdy and capturing Q/X/timeout into status.
module sm2201_camac_cycle_controller #(
  parameter logic [9:0] BASE_ADDR = 10'h300,
  parameter int         T_SETUP   = 1,
  parameter int         T_S1      = 2,
  parameter int         T_S2      = 2,
  parameter int         B_TIMEOUT = 64
) (
  input  logic                           isa_clk,
  input  logic                           isa_reset,
  sm2201_camac_cycle_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_B = 3'd1,
    ST_SETUP  = 3'd2,
    ST_S1     = 3'd3,
    ST_GAP    = 3'd4,
    ST_S2     = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_ior_d;
  logic       r_iow_d;
  logic [4:0] r_n;
  logic [4:0] r_f;
  logic [3:0] r_a;
  logic [2:0] r_status;
  logic       r_chrdy;
  logic       r_s1;
  logic       r_s2;
  logic       r_busy;
  logic       r_rd_latch_en;
  logic [4:0] r_camac_n;
  logic [3:0] r_camac_a;
  logic [4:0] r_camac_f;

  logic w_hit;
  logic w_rd_start;
  logic w_wr_start;
  logic w_cam_start;
  logic w_n_wr;
  logic w_f_wr;
  logic w_s1_last;
  logic w_b_timeout;
  logic w_on_bus;
  logic w_rd_pulse;
  logic w_unused;

  // A start is a falling edge on exactly one strobe while the other stays high.
  assign w_hit       = (bus.isa_addr[9:5] == BASE_ADDR[9:5]) && !bus.isa_aen;
  assign w_rd_start  = w_hit && !bus.isa_ior && bus.isa_iow && r_ior_d;
  assign w_wr_start  = w_hit && !bus.isa_iow && bus.isa_ior && r_iow_d;
  assign w_cam_start = (r_state == ST_IDLE) && (w_rd_start || w_wr_start) && bus.isa_addr[4];
  assign w_n_wr      = (r_state == ST_IDLE) && w_wr_start && (bus.isa_addr[4:0] == 5'h00);
  assign w_f_wr      = (r_state == ST_IDLE) && w_wr_start && (bus.isa_addr[4:0] == 5'h01);
  assign w_s1_last   = (r_state == ST_S1) && (r_cnt == 8'(T_S1 - 1));
  assign w_b_timeout = (r_state == ST_WAIT_B) && bus.camac_b && (r_cnt == 8'(B_TIMEOUT));
  assign w_unused    = ^{bus.isa_data_in[7:5]};

  // Next-state and phase counter; the counter doubles as the busy-wait timer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_cam_start) begin
          w_state_nxt = ST_WAIT_B;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt   = 8'd0;
        end
      end
      ST_WAIT_B: begin
        if (!bus.camac_b) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == 8'(B_TIMEOUT)) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end else begin
          w_cnt_nxt   = r_cnt;
        end
      end
      ST_SETUP: begin
        if (r_cnt == 8'(T_SETUP - 1)) begin
          w_state_nxt = ST_S1;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      ST_S1: begin
        if (r_cnt == 8'(T_S1 - 1)) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_S2;
        w_cnt_nxt   = 8'd0;
      end
      ST_S2: begin
        if (r_cnt == 8'(T_S2 - 1)) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      ST_DONE: begin
        if (bus.isa_ior && bus.isa_iow) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
        w_cnt_nxt = 8'd0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every dataway pin comes off a flop.
  always_comb begin
    w_on_bus   = 1'b0;
    w_rd_pulse = 1'b0;
    case (w_state_nxt)
      ST_SETUP, ST_S1, ST_GAP, ST_S2: w_on_bus = 1'b1;
      default:                        w_on_bus = 1'b0;
    endcase
    if ((w_state_nxt == ST_S1) && (w_cnt_nxt == 8'(T_S1 - 1)) && (r_f[4:3] == 2'b00)) begin
      w_rd_pulse = 1'b1;
    end else begin
      w_rd_pulse = 1'b0;
    end
  end

  // State, command edge detect, N/F/A registers, status and registered outputs.
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 8'd0;
      r_ior_d       <= 1'b1;
      r_iow_d       <= 1'b1;
      r_n           <= 5'd0;
      r_f           <= 5'd0;
      r_a           <= 4'd0;
      r_status      <= 3'd0;
      r_chrdy       <= 1'b1;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_busy        <= 1'b0;
      r_rd_latch_en <= 1'b0;
      r_camac_n     <= 5'd0;
      r_camac_a     <= 4'd0;
      r_camac_f     <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ior_d <= bus.isa_ior;
      r_iow_d <= bus.isa_iow;
      if (w_n_wr) r_n <= bus.isa_data_in[4:0];
      if (w_f_wr) r_f <= bus.isa_data_in[4:0];
      if (w_cam_start) r_a <= bus.isa_addr[3:0];
      // Status stays sticky until the next dataway cycle is requested.
      if (w_cam_start) begin
        r_status <= 3'd0;
      end else if (w_b_timeout) begin
        r_status[2] <= 1'b1;
      end else if (w_s1_last) begin
        r_status[1:0] <= {bus.camac_x, bus.camac_q};
      end
      r_chrdy       <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);
      r_s1          <= (w_state_nxt == ST_S1);
      r_s2          <= (w_state_nxt == ST_S2);
      r_busy        <= w_on_bus;
      r_rd_latch_en <= w_rd_pulse;
      r_camac_n     <= w_on_bus ? r_n : 5'd0;
      r_camac_a     <= w_on_bus ? (w_cam_start ? bus.isa_addr[3:0] : r_a) : 4'd0;
      r_camac_f     <= w_on_bus ? r_f : 5'd0;
    end
  end

  assign bus.isa_chrdy   = r_chrdy;
  assign bus.camac_s1    = r_s1;
  assign bus.camac_s2    = r_s2;
  assign bus.camac_busy  = r_busy;
  assign bus.rd_latch_en = r_rd_latch_en;
  assign bus.camac_n     = r_camac_n;
  assign bus.camac_a     = r_camac_a;
  assign bus.camac_f     = r_camac_f;
  assign bus.status      = {5'b00000, r_status};

endmodule
